dsp_out_accumulator: RTL and testbench
======================================

// Module: dsp_out_accumulator
//
// PURPOSE
//   Downstream consumer of the registered 4-bit DSP result stream. Sums
//   successive DSP outputs into a wider accumulator and groups them into
//   frames delimited by in_last. Returns each frame sum to the next stage
//   through a valid/ready handshake.
//   The upstream issuer aligns in_valid/in_last with the DSP output register.
//
// PARAMETERS
//   DATA_WIDTH   4   width of incoming DSP result (matches DSP out bus)
//   ACC_WIDTH   12   accumulator / frame-sum width; must be > DATA_WIDTH
//   COUNT_WIDTH  4   width of per-frame accepted-beat counter
//
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous, active-high reset
//   in_valid   in   1            in_data/in_last qualify this cycle
//   in_data    in   DATA_WIDTH   unsigned DSP result
//   in_last    in   1            beat is final beat of the frame
//   in_ready   out  1            block can accept a beat
//   out_valid  out  1            frame sum available
//   out_data   out  ACC_WIDTH    frame sum
//   out_count  out  COUNT_WIDTH  number of beats in the frame
//   out_ovf    out  1            frame sum exceeded ACC_WIDTH
//   out_ready  in   1            downstream accepts frame sum
//
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, acc=0, cnt=0, ovf=0.
//     Outputs: in_ready=1, out_valid=0, out_data=0, out_count=0, out_ovf=0.
//     Assertion mid-frame discards the partial sum with no output.
//   - States:
//       IDLE  : no beats in the frame.
//       ACCUM : >=1 beat accepted, no last yet.
//       DONE  : sum held for handshake.
//   - in_ready = (state != DONE), registered-free combinational decode of state.
//   - Accept = in_valid & in_ready.
//     Per accept:
//       acc <= acc + zero-extended in_data;
//       cnt <= cnt + 1, saturating at all-ones;
//       ovf <= ovf | carry-out of the ACC_WIDTH add.
//   - Transitions:
//       IDLE/ACCUM with accept & !in_last -> ACCUM.
//       IDLE/ACCUM with accept &  in_last -> DONE.
//       DONE with out_valid & out_ready   -> IDLE; acc, cnt, ovf cleared.
//   - Latency: the last beat accepted at edge N gives out_valid=1 after edge N.
//     out_data includes the last beat.
//   - A single-beat frame (in_last on the first beat) is legal: count=1.
//   - In DONE, out_data/out_count/out_ovf are stable until the handshake.
//     in_valid is ignored in DONE (backpressure). No beat is accepted on the
//     handshake cycle; the next beat is accepted one cycle later.
//   - in_valid=0 holds all state; idle cycles inside a frame are allowed.
//   - out_data, out_count and out_ovf are driven from the acc, cnt and ovf
//     registers in every state.
//
// CONFIGURATION
//   DSP_ACC_SATURATE_EN
//     Defined: on carry-out, acc clamps to 2^ACC_WIDTH-1 and stays there for
//     the rest of the frame; out_ovf=1.
//     Undefined: acc wraps modulo 2^ACC_WIDTH; out_ovf=1 marks the wrap.
//     out_ovf semantics and the clear-on-handshake rule are identical in
//     both builds.
//
// TESTING
//   1. Reset, then frame 3,5,15(last), out_ready=1 ->
//      out_valid one cycle after the last beat; data=23, count=3, ovf=0.
//   2. Single beat 9 with in_last, out_ready=0 for 4 cycles ->
//      out_valid held, data=9, count=1; in_ready=0 throughout.
//      After out_ready=1: IDLE, in_ready=1.
//   3. Gaps: beats 1, idle x3, 2, idle, 4(last) -> data=7, count=3.
//   4. ACC_WIDTH=5: beats 15,15,15(last) ->
//      wrap build: data=13, ovf=1; DSP_ACC_SATURATE_EN build: data=31, ovf=1.
//   5. 17 beats of 1 with COUNT_WIDTH=4 -> data=17, count=15 (saturated).
//   6. rst pulsed after 2 beats of 6 ->
//      no out_valid; the next frame 2(last) gives data=2, count=1.

Source files
------------

// File: rtl/dsp_out_acc_if.sv
// +----------------------------------------------------------------------------+
// | dsp_out_acc_if : beat input / frame-sum output bundle for the accumulator  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dsp_out_acc_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int ACC_WIDTH   = 12,
  parameter int COUNT_WIDTH = 4
);
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   out_valid;
  logic [ACC_WIDTH-1:0]   out_data;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_ovf;
  logic                   out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/dsp_out_accumulator.sv
// +----------------------------------------------------------------------------+
// | dsp_out_accumulator : sums DSP result beats into per-frame sums            |
// | Option macro DSP_ACC_SATURATE_EN: clamp instead of wrap on overflow.      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module dsp_out_accumulator #(
  parameter int DATA_WIDTH  = 4,
  parameter int ACC_WIDTH   = 12,
  parameter int COUNT_WIDTH = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  dsp_out_acc_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ACC_WIDTH-1:0]   C_ACC_MAX = {ACC_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;

  logic                   accept;
  logic                   handshake;
  logic [ACC_WIDTH:0]     sum;
  logic                   carry;

  assign accept    = bus.in_valid && (state_q != ST_DONE);
  assign handshake = out_valid_q && bus.out_ready;
  assign sum       = {1'b0, acc_q} + {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, bus.in_data};
  assign carry     = sum[ACC_WIDTH];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
`ifdef DSP_ACC_SATURATE_EN
          // Once clamped, the sum stays pinned for the remainder of the frame.
          acc_d = (carry || ovf_q) ? C_ACC_MAX : sum[ACC_WIDTH-1:0];
`else
          acc_d = sum[ACC_WIDTH-1:0];
`endif
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + C_CNT_ONE;
          ovf_d   = ovf_q | carry;
          state_d = bus.in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (handshake) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q != ST_DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_out_accumulator.sv
// +----------------------------------------------------------------------------+
// | tb_dsp_out_accumulator : randomized + directed bench, wide and narrow DUT  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dsp_out_accumulator;

  localparam int DW   = 4;
  localparam int AW_A = 12;
  localparam int AW_B = 5;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsp_out_acc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW_A), .COUNT_WIDTH(CW)) bus_a ();
  dsp_out_acc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW_B), .COUNT_WIDTH(CW)) bus_b ();

  dsp_out_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW_A), .COUNT_WIDTH(CW)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dsp_out_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW_B), .COUNT_WIDTH(CW)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: plain integer frame sum and beat count; widths applied on compare.
  int frame_sum   = 0;
  int frame_beats = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_data(input int sum, input int aw);
    int lim;
    lim = 1 << aw;
`ifdef DSP_ACC_SATURATE_EN
    return (sum >= lim) ? lim - 1 : sum;
`else
    return sum % lim;
`endif
  endfunction

  function automatic int exp_count(input int beats);
    return (beats > (1 << CW) - 1) ? (1 << CW) - 1 : beats;
  endfunction

  function automatic int exp_ovf(input int sum, input int aw);
    return (sum >= (1 << aw)) ? 1 : 0;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = l; bus_a.out_ready = r;
    bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_last = l; bus_b.out_ready = r;
  endtask

  task automatic check_outputs(input string tag, input logic valid);
    check({tag, "_valid_a"}, 32'(bus_a.out_valid), 32'(valid));
    check({tag, "_valid_b"}, 32'(bus_b.out_valid), 32'(valid));
    check({tag, "_data_a"},  32'(bus_a.out_data),  exp_data(frame_sum, AW_A));
    check({tag, "_data_b"},  32'(bus_b.out_data),  exp_data(frame_sum, AW_B));
    check({tag, "_count_a"}, 32'(bus_a.out_count), exp_count(frame_beats));
    check({tag, "_count_b"}, 32'(bus_b.out_count), exp_count(frame_beats));
    check({tag, "_ovf_a"},   32'(bus_a.out_ovf),   exp_ovf(frame_sum, AW_A));
    check({tag, "_ovf_b"},   32'(bus_b.out_ovf),   exp_ovf(frame_sum, AW_B));
    check({tag, "_rdy_a"},   32'(bus_a.in_ready),  32'(!valid));
    check({tag, "_rdy_b"},   32'(bus_b.in_ready),  32'(!valid));
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    drive(1'b1, d, last, 1'b0);
    check("beat_rdy_a", 32'(bus_a.in_ready), 32'd1);
    check("beat_rdy_b", 32'(bus_b.in_ready), 32'd1);
    @(posedge clk);
    #1;
    frame_sum   += int'(d);
    frame_beats += 1;
    drive(1'b0, '0, 1'b0, 1'b0);
    check_outputs(last ? "last" : "mid", last);
  endtask

  // Hold DONE with garbage beats offered, then handshake and confirm the clear.
  task automatic finish_frame(input int hold);
    for (int i = 0; i < hold; i++) begin
      drive(1'b1, DW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      @(posedge clk);
      #1;
      check_outputs("hold", 1'b1);
    end
    drive(1'b1, DW'($urandom_range(1, 15)), 1'b1, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    frame_sum   = 0;
    frame_beats = 0;
    check_outputs("hs", 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset", 1'b0);

    // Three-beat frame, immediate acceptance downstream
    beat(4'd3, 1'b0);
    beat(4'd5, 1'b0);
    beat(4'd15, 1'b1);
    check("t1_data", 32'(bus_a.out_data), 32'd23);
    check("t1_count", 32'(bus_a.out_count), 32'd3);
    finish_frame(0);

    // Single-beat frame with backpressure
    beat(4'd9, 1'b1);
    check("t2_data", 32'(bus_a.out_data), 32'd9);
    check("t2_count", 32'(bus_a.out_count), 32'd1);
    finish_frame(4);

    // Idle gaps inside a frame
    beat(4'd1, 1'b0);
    idle(3);
    check_outputs("gap", 1'b0);
    beat(4'd2, 1'b0);
    idle(1);
    beat(4'd4, 1'b1);
    check("t3_data", 32'(bus_a.out_data), 32'd7);
    check("t3_count", 32'(bus_a.out_count), 32'd3);
    finish_frame(1);

    // Narrow accumulator overflow
    beat(4'd15, 1'b0);
    beat(4'd15, 1'b0);
    beat(4'd15, 1'b1);
`ifdef DSP_ACC_SATURATE_EN
    check("t4_data_b", 32'(bus_b.out_data), 32'd31);
`else
    check("t4_data_b", 32'(bus_b.out_data), 32'd13);
`endif
    check("t4_ovf_b", 32'(bus_b.out_ovf), 32'd1);
    check("t4_ovf_a", 32'(bus_a.out_ovf), 32'd0);
    finish_frame(0);

    // Beat counter saturation
    for (int i = 0; i < 17; i++) beat(4'd1, (i == 16));
    check("t5_data", 32'(bus_a.out_data), 32'd17);
    check("t5_count", 32'(bus_a.out_count), 32'd15);
    finish_frame(0);

    // Reset mid-frame discards the partial sum
    beat(4'd6, 1'b0);
    beat(4'd6, 1'b0);
    rst = 1'b1;
    #1;
    frame_sum   = 0;
    frame_beats = 0;
    check_outputs("rst_mid", 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rst", 1'b0);
    beat(4'd2, 1'b1);
    check("t6_data", 32'(bus_a.out_data), 32'd2);
    check("t6_count", 32'(bus_a.out_count), 32'd1);
    finish_frame(0);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        beat(DW'($urandom_range(0, 15)), (i == n - 1));
      end
      finish_frame($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
